// File: rtl/mxint_cast_arbiter.sv
// Shares one mxint_cast between NUM_REQ block producers: round-robin whole-block grant,
// one-block issue register, and tag FIFO routing results back. MXINT_CAST_ARB_FIXED_PRIORITY_EN
// selects a fixed-priority (lowest index) grant instead.
module mxint_cast_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned IN_MAN_WIDTH  = 8,
    parameter int unsigned IN_EXP_WIDTH  = 8,
    parameter int unsigned OUT_MAN_WIDTH = 8,
    parameter int unsigned OUT_EXP_WIDTH = 8,
    parameter int unsigned BLOCK_SIZE    = 4,
    parameter int unsigned TAG_DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_MAN_WIDTH-1:0]      req_mdata_in [NUM_REQ*BLOCK_SIZE],
    input  logic [IN_EXP_WIDTH-1:0]      req_edata_in [NUM_REQ],
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [IN_MAN_WIDTH-1:0]      cast_mdata_out [BLOCK_SIZE],
    output logic [IN_EXP_WIDTH-1:0]      cast_edata_out,
    output logic                         cast_valid,
    input  logic                         cast_ready,
    input  logic [OUT_MAN_WIDTH-1:0]     cast_mdata_in [BLOCK_SIZE],
    input  logic [OUT_EXP_WIDTH-1:0]     cast_edata_in,
    input  logic                         cast_result_valid,
    output logic                         cast_result_ready,
    output logic [OUT_MAN_WIDTH-1:0]     rsp_mdata_out [BLOCK_SIZE],
    output logic [OUT_EXP_WIDTH-1:0]     rsp_edata_out,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [$clog2(TAG_DEPTH):0]   in_flight,
    output logic                         tag_error
);

    localparam int unsigned ReqW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TagAw = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(TAG_DEPTH) + 1;

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e                  state_q, state_d;
    logic [ReqW-1:0]         grant;
    logic                    load, cast_hs, full, empty, pop;
    logic [ReqW-1:0]         head;

    logic [IN_MAN_WIDTH-1:0] sel_m [BLOCK_SIZE];
    logic [IN_EXP_WIDTH-1:0] sel_e;
    logic [IN_MAN_WIDTH-1:0] issue_m_q [BLOCK_SIZE];
    logic [IN_EXP_WIDTH-1:0] issue_e_q;

    logic [ReqW-1:0]         tag_mem_q [TAG_DEPTH];
    logic [TagAw-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]         count_q;
    logic                    tag_error_q;

`ifdef MXINT_CAST_ARB_FIXED_PRIORITY_EN
    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) grant = ReqW'(i);
        end
    end
`else
    logic [ReqW-1:0] rr_ptr_q;
    logic            rr_found;
    int              rr_idx;

    // Search starts just past the last winner and wraps.
    always_comb begin
        grant    = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            rr_idx = (int'(rr_ptr_q) + i) % int'(NUM_REQ);
            if (!rr_found && req_valid[ReqW'(rr_idx)]) begin
                grant    = ReqW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= ReqW'(NUM_REQ - 1);
        end else if (load) begin
            rr_ptr_q <= grant;
        end
    end
`endif

    assign full    = (count_q == CntW'(TAG_DEPTH));
    assign empty   = (count_q == '0);
    assign cast_hs = cast_valid && cast_ready;
    // A pop in the same cycle does not free a slot for issue.
    assign load    = ((state_q == StIdle) || cast_hs) && (|req_valid) && !full;

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = load;
    end

    always_comb begin
        for (int k = 0; k < int'(BLOCK_SIZE); k++) sel_m[k] = '0;
        sel_e = '0;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            if (grant == ReqW'(r)) begin
                for (int k = 0; k < int'(BLOCK_SIZE); k++) begin
                    sel_m[k] = req_mdata_in[r*int'(BLOCK_SIZE)+k];
                end
                sel_e = req_edata_in[r];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (load) state_d = StIssue;
            StIssue: if (cast_hs && !load) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            issue_e_q <= '0;
            for (int k = 0; k < int'(BLOCK_SIZE); k++) issue_m_q[k] <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                issue_e_q <= sel_e;
                for (int k = 0; k < int'(BLOCK_SIZE); k++) issue_m_q[k] <= sel_m[k];
            end
        end
    end

    assign cast_valid     = (state_q == StIssue);
    assign cast_mdata_out = issue_m_q;
    assign cast_edata_out = issue_e_q;

    // Tag FIFO: one entry per block handed to the cast, in issue order.
    assign head = tag_mem_q[rd_ptr_q];
    assign pop  = cast_result_valid && !empty && rsp_ready[head];

    always_ff @(posedge clk) begin
        if (load) tag_mem_q[wr_ptr_q] <= grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tag_error_q <= 1'b0;
        end else begin
            if (load) begin
                wr_ptr_q <= (wr_ptr_q == TagAw'(TAG_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == TagAw'(TAG_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (load && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !load) begin
                count_q <= count_q - 1'b1;
            end
            if (cast_result_valid && empty) tag_error_q <= 1'b1;
        end
    end

    always_comb begin
        rsp_valid       = '0;
        rsp_valid[head] = cast_result_valid && !empty;
    end

    // With no outstanding tag the result is accepted and dropped.
    assign cast_result_ready = empty || rsp_ready[head];
    assign rsp_mdata_out     = cast_mdata_in;
    assign rsp_edata_out     = cast_edata_in;
    assign in_flight         = count_q;
    assign tag_error         = tag_error_q;

endmodule
